// File: rtl/stack_pkg.sv
// Shared types and default widths for the stack sequencer.
//   op_t    : stack operation encoding presented on op_code
//   state_t : sequencer phase (IDLE -> RD -> WB)
package stack_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_ADDR_W = 3;

   typedef enum logic [2:0] {
      NOP  = 3'd0,
      PUSH = 3'd1,
      POP  = 3'd2,
      DUP  = 3'd3,
      SWAP = 3'd4,
      ADD  = 3'd5,
      SUB  = 3'd6,
      CLR  = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WB   = 2'd2
   } state_t;

endpackage

// File: rtl/stack_alu.sv
// Stack datapath: computes the regfile write values and the new top-of-stack
// for one op, given the top (t), next-on-stack (s) and the PUSH immediate.
//   op       : operation being committed
//   t, s     : regfile read data for TOS / NOS
//   imm      : PUSH operand
//   result_a : write-port A data
//   result_b : write-port B data (only used by SWAP)
//   new_top  : top value after the op, assuming the stack is non-empty
module stack_alu
   import stack_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  op_t               op,
   input  logic [DATA_W-1:0] t,
   input  logic [DATA_W-1:0] s,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] result_a,
   output logic [DATA_W-1:0] result_b,
   output logic [DATA_W-1:0] new_top
);

   // Result selection per op; arithmetic wraps at DATA_W bits.
   always_comb begin
      result_a = '0;
      result_b = t;
      new_top  = '0;
      case (op)
         PUSH: begin
            result_a = imm;
            new_top  = imm;
         end
         POP: new_top = s;
         DUP: begin
            result_a = t;
            new_top  = t;
         end
         SWAP: begin
            result_a = s;
            new_top  = s;
         end
         ADD: begin
            result_a = s + t;
            new_top  = s + t;
         end
         SUB: begin
            result_a = s - t;
            new_top  = s - t;
         end
         default: begin
            result_a = '0;
            new_top  = '0;
         end
      endcase
   end

endmodule

// File: rtl/stack_sequencer.sv
// Stack sequencer: owns the stack pointer and turns accepted stack ops into
// 2R/2W register-file traffic. Every op runs IDLE -> RD -> WB.
//   clk, rst             : clock, async active-high reset
//   op_valid/op_ready    : op handshake (ready only in IDLE)
//   op_code, op_imm      : operation and PUSH operand
//   re_sel_a/b           : regfile read selects (TOS / NOS), driven during RD
//   re_data_a/b          : regfile read data, valid in WB
//   wr_sel_a/b, wr_en_a/b: regfile write selects/strobes, active in WB
//   wr_data_a/b          : regfile write data
//   tos, depth, ovf, unf : top value, entry count, sticky status flags
module stack_sequencer
   import stack_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              op_valid,
   output logic              op_ready,
   input  op_t               op_code,
   input  logic [DATA_W-1:0] op_imm,
   output logic [ADDR_W-1:0] re_sel_a,
   output logic [ADDR_W-1:0] re_sel_b,
   input  logic [DATA_W-1:0] re_data_a,
   input  logic [DATA_W-1:0] re_data_b,
   output logic [ADDR_W-1:0] wr_sel_a,
   output logic [ADDR_W-1:0] wr_sel_b,
   output logic [DATA_W-1:0] wr_data_a,
   output logic [DATA_W-1:0] wr_data_b,
   output logic              wr_en_a,
   output logic              wr_en_b,
   output logic [DATA_W-1:0] tos,
   output logic [ADDR_W:0]   depth,
   output logic              ovf,
   output logic              unf
);

   localparam int unsigned SP_W    = ADDR_W + 1;
   localparam logic [SP_W-1:0] DEPTH_V = SP_W'(2 ** ADDR_W);

   state_t            state;
   op_t               op_q;
   logic [DATA_W-1:0] imm_q;
   logic [SP_W-1:0]   sp;

   logic [ADDR_W-1:0] sp_lo;
   logic [ADDR_W-1:0] sp_m1;
   logic [ADDR_W-1:0] sp_m2;
   logic              ovf_hit;
   logic              unf_hit;
   logic              guard;
   logic [SP_W-1:0]   sp_next;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_top;

   assign depth = sp;

   // Regfile indices relative to the stack pointer, wrapping mod DEPTH.
   assign sp_lo = ADDR_W'(sp);
   assign sp_m1 = ADDR_W'(sp - SP_W'(1));
   assign sp_m2 = ADDR_W'(sp - SP_W'(2));

   // Guard and next-sp depend only on the latched op and sp, both stable
   // through RD and WB, so they serve both the write-enable and commit edges.
   always_comb begin
      ovf_hit = 1'b0;
      unf_hit = 1'b0;
      sp_next = sp;
      case (op_q)
         PUSH: begin
            ovf_hit = (sp == DEPTH_V);
            sp_next = sp + SP_W'(1);
         end
         POP: begin
            unf_hit = (sp == '0);
            sp_next = sp - SP_W'(1);
         end
         DUP: begin
            ovf_hit = (sp == DEPTH_V);
            unf_hit = (sp == '0);
            sp_next = sp + SP_W'(1);
         end
         SWAP: unf_hit = (sp < SP_W'(2));
         ADD, SUB: begin
            unf_hit = (sp < SP_W'(2));
            sp_next = sp - SP_W'(1);
         end
         CLR: sp_next = '0;
         default: sp_next = sp;
      endcase
      guard = ovf_hit | unf_hit;
   end

   stack_alu #(.DATA_W(DATA_W)) u_alu (
      .op       (op_q),
      .t        (re_data_a),
      .s        (re_data_b),
      .imm      (imm_q),
      .result_a (alu_a),
      .result_b (alu_b),
      .new_top  (alu_top)
   );

   // Write data depends on read data that only arrives in WB, so it is a
   // direct function of the ALU result, held at zero outside an active write.
   assign wr_data_a = (state == WB && wr_en_a) ? alu_a : '0;
   assign wr_data_b = (state == WB && wr_en_b) ? alu_b : '0;

   // Sequencer: latch on accept, issue reads in RD, write/commit in WB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         op_q     <= NOP;
         imm_q    <= '0;
         sp       <= '0;
         op_ready <= 1'b1;
         re_sel_a <= '0;
         re_sel_b <= '0;
         wr_sel_a <= '0;
         wr_sel_b <= '0;
         wr_en_a  <= 1'b0;
         wr_en_b  <= 1'b0;
         tos      <= '0;
         ovf      <= 1'b0;
         unf      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (op_valid) begin
                  op_q     <= op_code;
                  imm_q    <= op_imm;
                  re_sel_a <= sp_m1;
                  re_sel_b <= sp_m2;
                  op_ready <= 1'b0;
                  state    <= RD;
               end
            end
            RD: begin
               state <= WB;
               if (!guard) begin
                  case (op_q)
                     PUSH, DUP: begin
                        wr_en_a  <= 1'b1;
                        wr_sel_a <= sp_lo;
                     end
                     SWAP: begin
                        wr_en_a  <= 1'b1;
                        wr_sel_a <= sp_m1;
                        wr_en_b  <= 1'b1;
                        wr_sel_b <= sp_m2;
                     end
                     ADD, SUB: begin
                        wr_en_a  <= 1'b1;
                        wr_sel_a <= sp_m2;
                     end
                     default: begin
                        wr_en_a <= 1'b0;
                        wr_en_b <= 1'b0;
                     end
                  endcase
               end
            end
            WB: begin
               state    <= IDLE;
               op_ready <= 1'b1;
               wr_en_a  <= 1'b0;
               wr_en_b  <= 1'b0;
               if (op_q == CLR) begin
                  sp  <= '0;
                  tos <= '0;
                  ovf <= 1'b0;
                  unf <= 1'b0;
               end else if (guard) begin
                  ovf <= ovf | ovf_hit;
                  unf <= unf | unf_hit;
               end else if (op_q != NOP) begin
                  sp  <= sp_next;
                  tos <= (sp_next == '0) ? '0 : alu_top;
               end
            end
            default: begin
               state    <= IDLE;
               op_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: behavioural 2R/2W regfile, queue-based stack
// model, per-cycle output comparison, directed cases and random op streams.
module tb_stack_sequencer;
   import stack_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       op_valid;
   logic       op_ready;
   op_t        op_code;
   logic [7:0] op_imm;
   logic [2:0] re_sel_a, re_sel_b, wr_sel_a, wr_sel_b;
   logic [7:0] re_data_a, re_data_b, wr_data_a, wr_data_b;
   logic       wr_en_a, wr_en_b;
   logic [7:0] tos;
   logic [3:0] depth;
   logic       ovf, unf;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   stack_sequencer dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .op_imm(op_imm),
      .re_sel_a(re_sel_a), .re_sel_b(re_sel_b),
      .re_data_a(re_data_a), .re_data_b(re_data_b),
      .wr_sel_a(wr_sel_a), .wr_sel_b(wr_sel_b),
      .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
      .wr_en_a(wr_en_a), .wr_en_b(wr_en_b),
      .tos(tos), .depth(depth), .ovf(ovf), .unf(unf)
   );

   // Behavioural register file with registered read.
   logic [7:0] mem [8];
   always @(posedge clk) begin
      re_data_a <= mem[re_sel_a];
      re_data_b <= mem[re_sel_b];
      if (wr_en_a) mem[wr_sel_a] <= wr_data_a;
      if (wr_en_b) mem[wr_sel_b] <= wr_data_b;
   end

   // Stack model: queue contents, op phase since accept, sticky flags.
   logic [7:0] stk [$];
   int         ph;
   op_t        cur_op;
   logic [7:0] cur_imm;
   logic       m_ovf, m_unf;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      stk.delete();
      ph = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic model_apply();
      int n;
      logic [7:0] t, s;
      n = stk.size();
      case (cur_op)
         PUSH: if (n == 8) m_ovf = 1'b1; else stk.push_back(cur_imm);
         POP:  if (n == 0) m_unf = 1'b1; else void'(stk.pop_back());
         DUP: begin
            if (n == 0) m_unf = 1'b1;
            if (n == 8) m_ovf = 1'b1;
            if (n > 0 && n < 8) stk.push_back(stk[n-1]);
         end
         SWAP, ADD, SUB: begin
            if (n < 2) m_unf = 1'b1;
            else begin
               t = stk.pop_back();
               s = stk.pop_back();
               if (cur_op == SWAP) begin
                  stk.push_back(t);
                  stk.push_back(s);
               end else if (cur_op == ADD) stk.push_back(8'(s + t));
               else stk.push_back(8'(s - t));
            end
         end
         CLR: begin
            stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
         default: ;
      endcase
   endtask

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic model_edge();
      if (rst) model_reset();
      else if (ph == 0) begin
         if (op_valid) begin
            cur_op  = op_code;
            cur_imm = op_imm;
            ph = 1;
         end
      end else if (ph == 1) ph = 2;
      else begin
         model_apply();
         ph = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Per-cycle comparison of every meaningful output against the model.
   int         c_n;
   logic [7:0] c_top, c_da, c_db;
   logic [2:0] c_sa, c_sb;
   logic       c_ea, c_eb;
   always @(negedge clk) begin
      c_n   = stk.size();
      c_top = (c_n == 0) ? 8'h00 : stk[c_n-1];
      chk("op_ready", {31'd0, op_ready}, {31'd0, ph == 0});
      chk("depth", {28'd0, depth}, c_n);
      chk("tos", {24'd0, tos}, {24'd0, c_top});
      chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
      chk("unf", {31'd0, unf}, {31'd0, m_unf});
      if (ph == 1) begin
         chk("re_sel_a", {29'd0, re_sel_a}, {29'd0, 3'(c_n - 1)});
         chk("re_sel_b", {29'd0, re_sel_b}, {29'd0, 3'(c_n - 2)});
      end
      c_ea = 1'b0; c_eb = 1'b0; c_sa = '0; c_sb = '0; c_da = '0; c_db = '0;
      if (ph == 2) begin
         case (cur_op)
            PUSH: if (c_n < 8) begin
               c_ea = 1'b1; c_sa = 3'(c_n); c_da = cur_imm;
            end
            DUP: if (c_n > 0 && c_n < 8) begin
               c_ea = 1'b1; c_sa = 3'(c_n); c_da = stk[c_n-1];
            end
            SWAP: if (c_n >= 2) begin
               c_ea = 1'b1; c_sa = 3'(c_n - 1); c_da = stk[c_n-2];
               c_eb = 1'b1; c_sb = 3'(c_n - 2); c_db = stk[c_n-1];
            end
            ADD: if (c_n >= 2) begin
               c_ea = 1'b1; c_sa = 3'(c_n - 2); c_da = 8'(stk[c_n-2] + stk[c_n-1]);
            end
            SUB: if (c_n >= 2) begin
               c_ea = 1'b1; c_sa = 3'(c_n - 2); c_da = 8'(stk[c_n-2] - stk[c_n-1]);
            end
            default: ;
         endcase
      end
      chk("wr_en_a", {31'd0, wr_en_a}, {31'd0, c_ea});
      chk("wr_en_b", {31'd0, wr_en_b}, {31'd0, c_eb});
      if (c_ea) begin
         chk("wr_sel_a", {29'd0, wr_sel_a}, {29'd0, c_sa});
         chk("wr_data_a", {24'd0, wr_data_a}, {24'd0, c_da});
      end
      if (c_eb) begin
         chk("wr_sel_b", {29'd0, wr_sel_b}, {29'd0, c_sb});
         chk("wr_data_b", {24'd0, wr_data_b}, {24'd0, c_db});
      end
   end

   // Write activity captured during the WB cycle of the last op.
   logic       l_ea, l_eb;
   logic [2:0] l_sa, l_sb;
   logic [7:0] l_da, l_db;

   task automatic do_op(input op_t op, input logic [7:0] imm);
      int g;
      g = 0;
      while (!op_ready && g < 8) begin
         tick();
         g++;
      end
      chk("ready_wait", {31'd0, g < 8}, 32'd1);
      op_valid = 1'b1;
      op_code  = op;
      op_imm   = imm;
      tick();
      // Ignored while busy: scramble the op fields.
      op_valid = 1'($urandom);
      op_code  = op_t'($urandom_range(0, 7));
      op_imm   = 8'($urandom);
      tick();
      l_ea = wr_en_a; l_eb = wr_en_b;
      l_sa = wr_sel_a; l_sb = wr_sel_b;
      l_da = wr_data_a; l_db = wr_data_b;
      op_valid = 1'b0;
      tick();
   endtask

   int  acc;
   logic seen;

   initial begin
      rst = 1'b1;
      op_valid = 1'b0;
      op_code = NOP;
      op_imm = 8'h00;
      model_reset();
      tick();
      chk("rst_ready", {31'd0, op_ready}, 32'd1);
      chk("rst_depth", {28'd0, depth}, 32'd0);
      chk("rst_tos", {24'd0, tos}, 32'd0);
      chk("rst_wr_en", {30'd0, wr_en_a, wr_en_b}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // PUSH 5, PUSH 7, ADD
      do_op(PUSH, 8'd5);
      do_op(PUSH, 8'd7);
      do_op(ADD, 8'd0);
      chk("add_wr", {20'd0, l_ea, l_sa, l_da}, {20'd0, 1'b1, 3'd0, 8'd12});
      chk("add_tos", {24'd0, tos}, 32'd12);
      chk("add_depth", {28'd0, depth}, 32'd1);
      chk("add_mem0", {24'd0, mem[0]}, 32'd12);

      // PUSH 3, PUSH 9, SWAP
      do_op(CLR, 8'd0);
      do_op(PUSH, 8'd3);
      do_op(PUSH, 8'd9);
      do_op(SWAP, 8'd0);
      chk("swap_wr_a", {20'd0, l_ea, l_sa, l_da}, {20'd0, 1'b1, 3'd1, 8'd3});
      chk("swap_wr_b", {20'd0, l_eb, l_sb, l_db}, {20'd0, 1'b1, 3'd0, 8'd9});
      chk("swap_tos", {24'd0, tos}, 32'd3);
      chk("swap_depth", {28'd0, depth}, 32'd2);

      // PUSH 2, PUSH 5, SUB wraps; ADD at depth 1 underflows
      do_op(CLR, 8'd0);
      do_op(PUSH, 8'd2);
      do_op(PUSH, 8'd5);
      do_op(SUB, 8'd0);
      chk("sub_tos", {24'd0, tos}, 32'hFD);
      chk("sub_depth", {28'd0, depth}, 32'd1);
      do_op(ADD, 8'd0);
      chk("add1_unf", {31'd0, unf}, 32'd1);
      chk("add1_no_wr", {30'd0, l_ea, l_eb}, 32'd0);
      chk("add1_depth", {28'd0, depth}, 32'd1);

      // Fill to DEPTH then overflow; CLR recovers
      do_op(CLR, 8'd0);
      for (int i = 0; i < 8; i++) do_op(PUSH, 8'(i));
      do_op(PUSH, 8'hAA);
      chk("full_ovf", {31'd0, ovf}, 32'd1);
      chk("full_depth", {28'd0, depth}, 32'd8);
      chk("full_tos", {24'd0, tos}, 32'd7);
      chk("full_no_wr", {30'd0, l_ea, l_eb}, 32'd0);
      do_op(CLR, 8'd0);
      chk("clr_ovf", {31'd0, ovf}, 32'd0);
      chk("clr_depth", {28'd0, depth}, 32'd0);
      chk("clr_tos", {24'd0, tos}, 32'd0);

      // POP on empty; DUP
      do_op(POP, 8'd0);
      chk("pop_unf", {31'd0, unf}, 32'd1);
      chk("pop_depth", {28'd0, depth}, 32'd0);
      do_op(CLR, 8'd0);
      do_op(PUSH, 8'h42);
      do_op(DUP, 8'd0);
      chk("dup_wr", {20'd0, l_ea, l_sa, l_da}, {20'd0, 1'b1, 3'd1, 8'h42});
      chk("dup_depth", {28'd0, depth}, 32'd2);

      // Continuous valid: one accept every three cycles
      do_op(CLR, 8'd0);
      acc = 0;
      op_valid = 1'b1;
      op_code  = PUSH;
      op_imm   = 8'h11;
      for (int i = 0; i < 12; i++) begin
         if (op_ready) acc++;
         tick();
      end
      op_valid = 1'b0;
      chk("stream_accepts", acc, 32'd4);
      chk("stream_depth", {28'd0, depth}, 32'd4);

      // Reset while in RD drops the op
      op_valid = 1'b1;
      op_code  = PUSH;
      op_imm   = 8'h55;
      tick();
      op_valid = 1'b0;
      rst = 1'b1;
      model_reset();
      seen = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         seen = seen | wr_en_a | wr_en_b;
         tick();
      end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         seen = seen | wr_en_a | wr_en_b;
         tick();
      end
      chk("rst_rd_no_wr", {31'd0, seen}, 32'd0);
      chk("rst_rd_depth", {28'd0, depth}, 32'd0);

      // Random op stream
      for (int i = 0; i < 300; i++) begin
         op_t o;
         o = op_t'($urandom_range(0, 7));
         if (o == CLR && $urandom_range(0, 3) != 0) o = PUSH;
         do_op(o, 8'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
